// File: rtl/wb_target_mem.sv
// Wishbone classic-cycle target backed by a word-addressed RAM.
// Requests are captured in IDLE, optionally delayed by WAIT_CYCLES, then
// terminated with a single-cycle ack (in window) or err (out of window).
module wb_target_mem #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] dat_w,
  output logic [31:0] dat_r,
  input  logic [3:0]  sel,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  output logic        ack,
  output logic        err,
  output logic [31:0] xfer_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK = ~(32'(DEPTH) * 32'd4 - 32'd1);
  localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   wdat_q;
  logic          hit_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   dat_r_q;
  logic [31:0]   xfer_q;
  logic [31:0]   mem_q [DEPTH];

  logic          req_hit;
  logic          go_resp;
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic          r_hit;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdat;

  // Decide whether this edge enters RESP and which request fields apply.
  // With no wait states the live bus is used directly; otherwise the
  // fields captured in IDLE are used when the wait count expires.
  always_comb begin
    req_hit = ((adr & WIN_MASK) == BASE_ADDR);
    go_resp = 1'b0;
    r_idx   = idx_q;
    r_we    = we_q;
    r_sel   = sel_q;
    r_wdat  = wdat_q;
    r_hit   = hit_q;
    if (state_q == S_IDLE && cyc && stb && WAIT_CYCLES == 0) begin
      go_resp = 1'b1;
      r_idx   = adr[AW+1:2];
      r_we    = we;
      r_sel   = sel;
      r_wdat  = dat_w;
      r_hit   = req_hit;
    end else if (state_q == S_WAIT && cyc && cnt_q == '0) begin
      go_resp = 1'b1;
    end
  end

  // RAM byte-lane write, committed on the edge entering RESP; not reset.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && r_hit && r_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_sel[i]) mem_q[r_idx][8*i +: 8] <= r_wdat[8*i +: 8];
      end
    end
  end

  // Request FSM with registered ack/err/read data and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      xfer_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cyc && stb) begin
            idx_q  <= adr[AW+1:2];
            we_q   <= we;
            sel_q  <= sel;
            wdat_q <= dat_w;
            hit_q  <= req_hit;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!cyc)              state_q <= S_IDLE;
          else if (cnt_q == '0)  state_q <= S_RESP;
          else                   cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (go_resp) begin
        ack_q <= r_hit;
        err_q <= !r_hit;
        if (!r_hit)    dat_r_q <= '0;
        else if (!r_we) dat_r_q <= mem_q[r_idx];
        if (r_hit)     xfer_q  <= xfer_q + 32'd1;
      end
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign dat_r      = dat_r_q;
  assign xfer_count = xfer_q;

endmodule
